// File: rtl/inst_i_decoder.sv
// rtl/inst_i_decoder.sv - registered RV32I I-type decoder (optional INST_I_DEC_SEXT_EN adds imm_sext)
module inst_i_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instruction_word,
  output logic        out_valid,
  output logic [11:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        is_load,
  output logic        is_alu_imm,
  output logic        is_jalr,
`ifdef INST_I_DEC_SEXT_EN
  output logic [31:0] imm_sext,
`endif
  output logic        illegal
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] SHAMT_HI_SRA = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] word_funct3;
  logic [6:0] imm_hi;
  logic       dec_load;
  logic       dec_alu_imm;
  logic       dec_jalr;
  logic       dec_illegal;

  assign opcode      = instruction_word[6:0];
  assign word_funct3 = instruction_word[14:12];
  assign imm_hi      = instruction_word[31:25];

  // Classify the opcode and judge legality of funct3 / shift-immediate upper bits
  always_comb begin
    dec_load    = 1'b0;
    dec_alu_imm = 1'b0;
    dec_jalr    = 1'b0;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        dec_load    = 1'b1;
        // 011 is LD (RV64), 110 is LWU (RV64), 111 is reserved
        dec_illegal = (word_funct3 == 3'b011) || (word_funct3 == 3'b110) ||
                      (word_funct3 == 3'b111);
      end
      OPC_OP_IMM: begin
        dec_alu_imm = 1'b1;
        case (word_funct3)
          3'b001:  dec_illegal = (imm_hi != 7'b0000000);
          3'b101:  dec_illegal = !((imm_hi == 7'b0000000) || (imm_hi == SHAMT_HI_SRA));
          default: dec_illegal = 1'b0;
        endcase
      end
      OPC_JALR: begin
        dec_jalr    = 1'b1;
        dec_illegal = (word_funct3 != 3'b000);
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Output registers: reset clears all, a valid word loads all, otherwise fields hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      imm        <= 12'd0;
      rs1        <= 5'd0;
      rd         <= 5'd0;
      funct3     <= 3'd0;
      is_load    <= 1'b0;
      is_alu_imm <= 1'b0;
      is_jalr    <= 1'b0;
      illegal    <= 1'b0;
`ifdef INST_I_DEC_SEXT_EN
      imm_sext   <= 32'd0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm        <= instruction_word[31:20];
        rs1        <= instruction_word[19:15];
        rd         <= instruction_word[11:7];
        funct3     <= word_funct3;
        is_load    <= dec_load;
        is_alu_imm <= dec_alu_imm;
        is_jalr    <= dec_jalr;
        illegal    <= dec_illegal;
`ifdef INST_I_DEC_SEXT_EN
        imm_sext   <= {{20{instruction_word[31]}}, instruction_word[31:20]};
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_i_decoder.sv
// tb/tb_inst_i_decoder.sv - directed self-checking bench for inst_i_decoder
module tb_inst_i_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction_word;
  logic        out_valid;
  logic [11:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_alu_imm;
  logic        is_jalr;
  logic        illegal;
`ifdef INST_I_DEC_SEXT_EN
  logic [31:0] imm_sext;
`endif

  int total = 0;
  int bad   = 0;

  inst_i_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .imm              (imm),
    .rs1              (rs1),
    .rd               (rd),
    .funct3           (funct3),
    .is_load          (is_load),
    .is_alu_imm       (is_alu_imm),
    .is_jalr          (is_jalr),
`ifdef INST_I_DEC_SEXT_EN
    .imm_sext         (imm_sext),
`endif
    .illegal          (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then look 1 time unit later
  task automatic step(input logic r, input logic v, input logic [31:0] w);
    rst = r;
    in_valid = v;
    instruction_word = w;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [11:0] e_imm,
                            input logic [4:0] e_rs1, input logic [4:0] e_rd,
                            input logic [2:0] e_f3, input logic e_ld, input logic e_ai,
                            input logic e_jr, input logic e_ill);
    chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, v});
    chk({tag, ".imm"},        {20'd0, imm},        {20'd0, e_imm});
    chk({tag, ".rs1"},        {27'd0, rs1},        {27'd0, e_rs1});
    chk({tag, ".rd"},         {27'd0, rd},         {27'd0, e_rd});
    chk({tag, ".funct3"},     {29'd0, funct3},     {29'd0, e_f3});
    chk({tag, ".is_load"},    {31'd0, is_load},    {31'd0, e_ld});
    chk({tag, ".is_alu_imm"}, {31'd0, is_alu_imm}, {31'd0, e_ai});
    chk({tag, ".is_jalr"},    {31'd0, is_jalr},    {31'd0, e_jr});
    chk({tag, ".illegal"},    {31'd0, illegal},    {31'd0, e_ill});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    instruction_word = 32'd0;
    #2;

    // reset held with a valid word present: everything stays cleared
    step(1'b1, 1'b1, 32'hFFF00093);
    expect_all("rst1", 1'b0, 12'h000, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef INST_I_DEC_SEXT_EN
    chk("rst1.imm_sext", imm_sext, 32'h0);
`endif
    step(1'b1, 1'b1, 32'hFFF00093);
    expect_all("rst2", 1'b0, 12'h000, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LB
    step(1'b0, 1'b1, 32'b001000001001_10011_000_00111_0000011);
    expect_all("lb", 1'b1, 12'h209, 5'd19, 5'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // load funct3=111 reserved
    step(1'b0, 1'b1, 32'b011101101101_00001_111_00110_0000011);
    expect_all("ld_f7", 1'b1, 12'h76D, 5'd1, 5'd6, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);

    // LHU
    step(1'b0, 1'b1, 32'b000011110101_01101_101_01101_0000011);
    expect_all("lhu", 1'b1, 12'h0F5, 5'd13, 5'd13, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    // same word, funct3=011 (LD, RV64 only)
    step(1'b0, 1'b1, 32'b000011110101_01101_011_01101_0000011);
    expect_all("ld_f3", 1'b1, 12'h0F5, 5'd13, 5'd13, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);

    // funct3=110 (LWU)
    step(1'b0, 1'b1, 32'b000011110101_01101_110_01101_0000011);
    expect_all("ld_f6", 1'b1, 12'h0F5, 5'd13, 5'd13, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);

    // addi x1,x0,-1
    step(1'b0, 1'b1, 32'hFFF00093);
    expect_all("addi", 1'b1, 12'hFFF, 5'd0, 5'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef INST_I_DEC_SEXT_EN
    chk("addi.imm_sext", imm_sext, 32'hFFFFFFFF);
`endif

    // SRAI
    step(1'b0, 1'b1, 32'h40105093);
    expect_all("srai", 1'b1, 12'h401, 5'd0, 5'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef INST_I_DEC_SEXT_EN
    chk("srai.imm_sext", imm_sext, 32'h00000401);
`endif

    // SRLI
    step(1'b0, 1'b1, 32'h00105093);
    expect_all("srli", 1'b1, 12'h001, 5'd0, 5'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);

    // funct3=101 with bad imm[11:5]
    step(1'b0, 1'b1, 32'h60105093);
    expect_all("sr_bad", 1'b1, 12'h601, 5'd0, 5'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);

    // in_valid low: out_valid drops, fields and flags hold
    step(1'b0, 1'b0, 32'h00008067);
    expect_all("hold", 1'b0, 12'h601, 5'd0, 5'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);

    // SLLI with non-zero imm[11:5] (SRAI-style encoding) is illegal
    step(1'b0, 1'b1, 32'h40101093);
    expect_all("slli_bad", 1'b1, 12'h401, 5'd0, 5'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);

    // SLLI legal
    step(1'b0, 1'b1, 32'h00301093);
    expect_all("slli", 1'b1, 12'h003, 5'd0, 5'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // JALR x0,0(x1)
    step(1'b0, 1'b1, 32'h00008067);
    expect_all("jalr", 1'b1, 12'h000, 5'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // JALR with funct3=001
    step(1'b0, 1'b1, 32'h00009067);
    expect_all("jalr_f1", 1'b1, 12'h000, 5'd1, 5'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);

    // R-type opcode: no class, illegal
    step(1'b0, 1'b1, 32'h00208033);
    expect_all("rtype", 1'b1, 12'h002, 5'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // xori with negative imm (funct3=100 always legal)
    step(1'b0, 1'b1, 32'h80A14713);
    expect_all("xori", 1'b1, 12'h80A, 5'd2, 5'd14, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef INST_I_DEC_SEXT_EN
    chk("xori.imm_sext", imm_sext, 32'hFFFFF80A);
`endif

    // reset wins over in_valid after activity
    step(1'b1, 1'b1, 32'hFFF00093);
    expect_all("rst3", 1'b0, 12'h000, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef INST_I_DEC_SEXT_EN
    chk("rst3.imm_sext", imm_sext, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
